// File: rtl/alu_stack_ctrl.sv
// rtl/alu_stack_ctrl.sv - operand-stack sequencer feeding the shared combinational ALU
// Optional DUP/SWAP stack ops are compiled in when STACK_EXT_EN is defined.
module alu_stack_ctrl #(
   parameter int DEPTH = 8,
   parameter int DW    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [4:0]             cmd_f,
   input  logic [DW-1:0]          cmd_data,
   output logic [DW-1:0]          alu_a,
   output logic [DW-1:0]          alu_b,
   output logic [4:0]             alu_f,
   input  logic [DW-1:0]          alu_s,
   output logic [DW-1:0]          top,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   done,
   output logic                   err_ovf,
   output logic                   err_unf,
   output logic                   err_bad,
   input  logic                   err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   state_t state, state_nx;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] res;
   logic          unary;
   logic [AW-1:0] pidx, tidx, nidx;
   logic          accept, f_un, f_bin, has1, has2, full;
   logic          do_push, do_pop, do_alu, do_dup, do_swap, fin;
   logic          set_ovf, set_unf, set_bad;

   // pidx is the next free slot, tidx the top entry, nidx the one beneath it
   assign pidx = depth[AW-1:0];
   assign tidx = depth[AW-1:0] - AW'(1);
   assign nidx = depth[AW-1:0] - AW'(2);
   assign has1 = |depth;
   assign has2 = |depth[AW:1];
   assign full = (depth == FULL);
   assign top  = has1 ? mem[tidx] : '0;

   always_comb begin
      state_nx  = state;
      cmd_ready = (state == IDLE);
      accept    = cmd_valid && (state == IDLE);
      f_un      = cmd_f inside {5'b10000, 5'b10001, 5'b10010};
      f_bin     = !cmd_f[4];
      do_push   = 1'b0;
      do_pop    = 1'b0;
      do_alu    = 1'b0;
      do_dup    = 1'b0;
      do_swap   = 1'b0;
      fin       = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      set_bad   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  2'b00: begin
                     fin = 1'b1;
                     if (full) set_ovf = 1'b1;
                     else      do_push = 1'b1;
                  end
                  2'b01: begin
                     fin = 1'b1;
                     if (has1) do_pop  = 1'b1;
                     else      set_unf = 1'b1;
                  end
                  2'b10: begin
                     if (!(f_un || f_bin)) begin
                        set_bad = 1'b1;
                        fin     = 1'b1;
                     end else if ((f_un && !has1) || (f_bin && !has2)) begin
                        set_unf = 1'b1;
                        fin     = 1'b1;
                     end else begin
                        do_alu   = 1'b1;
                        state_nx = EXEC;
                     end
                  end
                  default: begin
                     fin = 1'b1;
`ifdef STACK_EXT_EN
                     if (!cmd_f[0]) begin
                        if (!has1)     set_unf = 1'b1;
                        else if (full) set_ovf = 1'b1;
                        else           do_dup  = 1'b1;
                     end else begin
                        if (!has2) set_unf = 1'b1;
                        else       do_swap = 1'b1;
                     end
`else
                     set_bad = 1'b1;
`endif
                  end
               endcase
            end
         end
         EXEC:    state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth   <= '0;
         done    <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_f   <= '0;
         unary   <= 1'b0;
         res     <= '0;
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
         err_bad <= 1'b0;
      end else begin
         done <= fin || (state == WB);
         if (do_push || do_dup)
            depth <= depth + (AW+1)'(1);
         else if (do_pop || ((state == WB) && !unary))
            depth <= depth - (AW+1)'(1);
         // operands only move at accept, so the ALU sees stable inputs through EXEC
         if (do_alu) begin
            alu_a <= mem[tidx];
            alu_b <= f_un ? '0 : mem[nidx];
            alu_f <= cmd_f;
            unary <= f_un;
         end
         if (state == EXEC) res <= alu_s;
         if (err_clr) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            err_bad <= 1'b0;
         end else begin
            if (set_ovf) err_ovf <= 1'b1;
            if (set_unf) err_unf <= 1'b1;
            if (set_bad) err_bad <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[pidx] <= cmd_data;
      if (do_dup)  mem[pidx] <= mem[tidx];
      if (do_swap) begin
         mem[tidx] <= mem[nidx];
         mem[nidx] <= mem[tidx];
      end
      if (state == WB) begin
         if (unary) mem[tidx] <= res;
         else       mem[nidx] <= res;
      end
   end

endmodule
